// File: rtl/ifetch_ir.sv
// Instruction fetch sequencer and instruction register: fetches the word at the
// current PC over req/gnt/rvalid, holds it for decode, then steps or jumps the PC.
module ifetch_ir #(
    parameter int         DWIDTH  = 16,
    parameter int         IWIDTH  = 16,
    parameter logic [3:0] OPC_JMP = 4'hA,
    parameter logic [3:0] OPC_HLT = 4'hF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic [DWIDTH-1:0] i_pc_in,
    output logic              o_pc_en,
    output logic [1:0]        o_pc_ctrl,
    output logic [7:0]        o_offset_addr,
    output logic              o_imem_req,
    output logic [DWIDTH-1:0] o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [IWIDTH-1:0] i_imem_rdata,
    output logic              o_ir_valid,
    output logic [IWIDTH-1:0] o_ir_out,
    output logic [DWIDTH-1:0] o_ir_pc,
    input  logic              i_ir_ready,
    output logic              o_halted,
    output logic [2:0]        o_dbg_state
);

    // Handshakes: a memory request transfers in the cycle where imem_req and
    // imem_gnt are both high; the IR transfers where ir_valid and ir_ready are both high.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_pc_en;
    logic [1:0]          r_pc_ctrl;
    logic [7:0]          r_offset_addr;
    logic                r_imem_req;
    logic [DWIDTH-1:0]   r_imem_addr;
    logic                r_ir_valid;
    logic [IWIDTH-1:0]   r_ir_out;
    logic [DWIDTH-1:0]   r_ir_pc;
    logic                r_halted;

    logic [3:0]          w_opcode;
    logic                w_is_jmp;
    logic                w_is_hlt;
    logic [DWIDTH-1:0]   w_jmp_pc;
    logic [DWIDTH-1:0]   w_next_pc;

    assign w_opcode = r_ir_out[IWIDTH-1 -: 4];
    assign w_is_jmp = (w_opcode == OPC_JMP);
    assign w_is_hlt = (w_opcode == OPC_HLT);

    always_comb begin
        w_jmp_pc      = '0;
        w_jmp_pc[7:0] = r_ir_out[7:0];
    end

    // imem_addr is registered so pc_in never reaches an output combinationally;
    // leaving UPDATE it is loaded with the PC the stage holds in the following REQ cycle.
    assign w_next_pc = w_is_jmp ? w_jmp_pc : r_ir_pc + DWIDTH'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_pc_en       <= 1'b0;
            r_pc_ctrl     <= 2'b00;
            r_offset_addr <= 8'h00;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= '0;
            r_ir_valid    <= 1'b0;
            r_ir_out      <= '0;
            r_ir_pc       <= '0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= i_pc_in;
                    end
                end
                S_REQ: begin
                    if (i_imem_gnt) begin
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b0;
                        r_ir_pc    <= r_imem_addr;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        r_state    <= S_HOLD;
                        r_ir_out   <= i_imem_rdata;
                        r_ir_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_ir_ready) begin
                        r_ir_valid <= 1'b0;
                        if (w_is_hlt) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state   <= S_UPDATE;
                            r_pc_en   <= 1'b1;
                            r_pc_ctrl <= w_is_jmp ? 2'b10 : 2'b01;
                            if (w_is_jmp) begin
                                r_offset_addr <= r_ir_out[7:0];
                            end
                        end
                    end
                end
                S_UPDATE: begin
                    r_pc_en   <= 1'b0;
                    r_pc_ctrl <= 2'b00;
                    if (i_run) begin
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_next_pc;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pc_en       = r_pc_en;
    assign o_pc_ctrl     = r_pc_ctrl;
    assign o_offset_addr = r_offset_addr;
    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_imem_addr;
    assign o_ir_valid    = r_ir_valid;
    assign o_ir_out      = r_ir_out;
    assign o_ir_pc       = r_ir_pc;
    assign o_halted      = r_halted;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ifetch_ir.sv
// Bench for ifetch_ir: PC-stage and instruction-memory models around the DUT,
// a program-order scoreboard, single-instruction vector table and directed corner cases.
module tb_ifetch_ir;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_run = 1'b0;
    logic [15:0] i_pc_in = '0;
    logic        o_pc_en;
    logic [1:0]  o_pc_ctrl;
    logic [7:0]  o_offset_addr;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [15:0] i_imem_rdata = '0;
    logic        o_ir_valid;
    logic [15:0] o_ir_out;
    logic [15:0] o_ir_pc;
    logic        i_ir_ready = 1'b0;
    logic        o_halted;
    logic [2:0]  o_dbg_state;

    ifetch_ir dut (
        .i_clk(clk), .i_rst(i_rst), .i_run(i_run), .i_pc_in(i_pc_in),
        .o_pc_en(o_pc_en), .o_pc_ctrl(o_pc_ctrl), .o_offset_addr(o_offset_addr),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_ir_valid(o_ir_valid), .o_ir_out(o_ir_out), .o_ir_pc(o_ir_pc),
        .i_ir_ready(i_ir_ready), .o_halted(o_halted), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    logic [15:0] pc_m;
    logic [31:0] exp_q[$];
    logic [15:0] last_acc;
    logic [15:0] pend_data;
    int gd_cfg, lat_cfg, rd_cfg, cur_gd, cur_lat, cur_rd;
    int req_seen, hold_seen, rv_cnt;
    bit pending, rnd, spur;
    int n_acc, n_upd, n_gnt;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc0;
        int          gd;
        int          lat;
        int          rd;
        logic [1:0]  e_ctrl;
        logic [7:0]  e_off;
        logic [15:0] e_next;
        logic        e_halt;
        int          e_cyc;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // One clock: check against models, cross the edge, then drive the next inputs.
    task automatic step();
        logic pe, granted, acc, stall;
        logic [1:0] pcc;
        logic [7:0] off;
        logic [15:0] gaddr, saddr;
        pe = o_pc_en; pcc = o_pc_ctrl; off = o_offset_addr;
        granted = o_imem_req && i_imem_gnt;
        gaddr = o_imem_addr;
        acc = o_ir_valid && i_ir_ready;
        stall = o_imem_req && !i_imem_gnt;
        saddr = o_imem_addr;
        if (o_imem_req) check("req_addr", o_imem_addr, pc_m);
        if (o_halted) check("halt_quiet", {o_imem_req, o_pc_en}, 0);
        if (acc) begin
            if (exp_q.size() == 0) fail_now("unexpected_delivery");
            else check("delivery", {o_ir_out, o_ir_pc}, exp_q.pop_front());
            last_acc = o_ir_out;
            n_acc++;
        end
        if (pe) begin
            n_upd++;
            if (last_acc[15:12] == 4'hA) check("upd_jmp", {pcc, off}, {2'b10, last_acc[7:0]});
            else check("upd_step", pcc, 2'b01);
        end else begin
            check("ctrl_idle", pcc, 2'b00);
        end
        if (granted) n_gnt++;
        @(posedge clk); #1;
        if (stall) check("req_stable", {o_imem_req, o_imem_addr}, {1'b1, saddr});
        if (pe && pcc == 2'b01) pc_m = 16'(pc_m + 1);
        else if (pe && pcc == 2'b10) pc_m = {8'h00, off};
        i_pc_in = pc_m;
        i_imem_rvalid = 1'b0;
        i_imem_rdata = 16'($urandom);
        if (granted) begin
            pending = 1'b1;
            cur_lat = rnd ? $urandom_range(1, 3) : lat_cfg;
            rv_cnt = cur_lat;
            pend_data = mem[gaddr[7:0]];
        end
        if (pending) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata = pend_data;
                pending = 1'b0;
            end
        end else if (spur && (o_imem_req || o_ir_valid) && $urandom_range(0, 3) == 0) begin
            i_imem_rvalid = 1'b1;
        end
        if (o_imem_req) begin
            if (req_seen == 0) cur_gd = rnd ? $urandom_range(0, 3) : gd_cfg;
            i_imem_gnt = (req_seen == cur_gd);
            req_seen++;
        end else begin
            i_imem_gnt = spur && ($urandom_range(0, 3) == 0);
            req_seen = 0;
        end
        if (o_ir_valid) begin
            if (hold_seen == 0) cur_rd = rnd ? $urandom_range(0, 3) : rd_cfg;
            i_ir_ready = (hold_seen >= cur_rd);
            hold_seen++;
        end else begin
            i_ir_ready = spur && ($urandom_range(0, 1) == 1);
            hold_seen = 0;
        end
    endtask

    task automatic do_reset(input int gd, input int lat, input int rd);
        i_rst = 1'b1; i_run = 1'b0;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_ir_ready = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b0;
        gd_cfg = gd; lat_cfg = lat; rd_cfg = rd;
        req_seen = 0; hold_seen = 0; rv_cnt = 0; pending = 1'b0;
        n_acc = 0; n_upd = 0; n_gnt = 0; last_acc = '0;
        pc_m = '0; i_pc_in = '0;
        exp_q.delete();
        check("reset_outputs",
              {o_pc_en, o_pc_ctrl, o_offset_addr, o_imem_req, o_imem_addr,
               o_ir_valid, o_ir_out, o_ir_pc, o_halted, o_dbg_state}, 0);
    endtask

    task automatic run_to_halt(input string name, input int limit, output int cyc);
        cyc = 0;
        while (!o_halted && cyc < limit) begin
            step();
            cyc++;
        end
        if (!o_halted) fail_now(name);
    endtask

    initial begin
        int cyc;
        logic [15:0] a0, pcx, w;
        logic last_hlt;

        vecs[0] = '{16'h1234, 16'h0005, 0, 1, 0, 2'b01, 8'h00, 16'h0006, 1'b0, 4};
        vecs[1] = '{16'hA0C3, 16'h0010, 1, 2, 0, 2'b10, 8'hC3, 16'h00C3, 1'b0, 6};
        vecs[2] = '{16'hF000, 16'h0007, 0, 1, 2, 2'b00, 8'h00, 16'h0000, 1'b1, 6};
        vecs[3] = '{16'hFFFF, 16'h0000, 2, 1, 1, 2'b00, 8'h00, 16'h0000, 1'b1, 7};
        vecs[4] = '{16'hA0FF, 16'hFFFF, 0, 3, 0, 2'b10, 8'hFF, 16'h00FF, 1'b0, 6};
        vecs[5] = '{16'hB0AA, 16'hFFFF, 0, 1, 0, 2'b01, 8'h00, 16'h0000, 1'b0, 4};
        vecs[6] = '{16'h9A12, 16'h0020, 3, 3, 3, 2'b01, 8'h00, 16'h0021, 1'b0, 12};
        vecs[7] = '{16'h0A00, 16'h00FE, 0, 1, 0, 2'b01, 8'h00, 16'h00FF, 1'b0, 4};
        rnd = 1'b0; spur = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Three sequential instructions then HLT; halt must persist with run high.
        do_reset(0, 1, 0);
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hF000;
        exp_q = '{{16'h1111, 16'h0000}, {16'h2222, 16'h0001}, {16'h3333, 16'h0002}, {16'hF000, 16'h0003}};
        i_run = 1'b1;
        run_to_halt("t1_halt_timeout", 60, cyc);
        check("t1_cycles", cyc, 16);
        check("t1_updates", n_upd, 3);
        check("t1_grants", n_gnt, 4);
        check("t1_drained", exp_q.size(), 0);
        for (int i = 0; i < 20; i++) step();
        check("t1_still_halted", {o_halted, o_dbg_state}, {1'b1, 3'd5});

        // Absolute jump to 0x35.
        do_reset(0, 1, 0);
        mem[2] = 16'hA035; mem[8'h35] = 16'h3333; mem[8'h36] = 16'hF000;
        exp_q = '{{16'h1111, 16'h0000}, {16'h2222, 16'h0001}, {16'hA035, 16'h0002},
                  {16'h3333, 16'h0035}, {16'hF000, 16'h0036}};
        i_run = 1'b1;
        cyc = 0;
        while (!(o_pc_en && o_pc_ctrl == 2'b10) && cyc < 40) begin step(); cyc++; end
        if (cyc >= 40) fail_now("t2_jump_timeout");
        check("t2_offset", o_offset_addr, 8'h35);
        step();
        check("t2_next_addr", {o_imem_req, o_imem_addr}, {1'b1, 16'h0035});
        run_to_halt("t2_halt_timeout", 60, cyc);
        check("t2_drained", exp_q.size(), 0);

        // Decode stalls five cycles in HOLD.
        do_reset(0, 1, 5);
        mem[0] = 16'h1234; mem[1] = 16'hF000;
        exp_q = '{{16'h1234, 16'h0000}, {16'hF000, 16'h0001}};
        i_run = 1'b1;
        cyc = 0;
        while (!o_ir_valid && cyc < 20) begin step(); cyc++; end
        if (!o_ir_valid) fail_now("t3_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", {o_ir_valid, o_ir_out, o_pc_en, o_imem_req}, {1'b1, 16'h1234, 2'b00});
            step();
        end
        check("t3_hold_last", {o_ir_valid, o_ir_out}, {1'b1, 16'h1234});
        step();
        check("t3_update", {o_pc_en, o_pc_ctrl, o_ir_valid}, {1'b1, 2'b01, 1'b0});
        run_to_halt("t3_halt_timeout", 80, cyc);

        // Grant withheld for three REQ cycles.
        do_reset(3, 1, 0);
        mem[0] = 16'h5555; mem[1] = 16'hF000;
        exp_q = '{{16'h5555, 16'h0000}, {16'hF000, 16'h0001}};
        i_run = 1'b1;
        step();
        a0 = o_imem_addr;
        check("t4_first_req", {o_imem_req, o_imem_addr}, {1'b1, 16'h0000});
        for (int i = 0; i < 3; i++) begin
            check("t4_req_held", {o_imem_req, o_imem_addr}, {1'b1, a0});
            step();
        end
        check("t4_granted_cycle", {o_imem_req, i_imem_gnt}, 2'b11);
        step();
        check("t4_req_dropped", o_imem_req, 1'b0);
        run_to_halt("t4_halt_timeout", 60, cyc);
        check("t4_grants", n_gnt, 2);

        // Reset in WAIT with a stale response arriving afterwards.
        do_reset(0, 2, 0);
        mem[0] = 16'h7777; mem[1] = 16'hF000;
        i_run = 1'b1;
        step();
        step();
        check("t6_in_wait", {o_imem_req, o_dbg_state}, {1'b0, 3'd2});
        i_rst = 1'b1; i_run = 1'b0;
        #2;
        i_rst = 1'b0;
        check("t6_after_rst", {o_imem_req, o_ir_valid, o_ir_out, o_ir_pc, o_dbg_state}, 0);
        step();
        check("t6_stale_rvalid_driven", i_imem_rvalid, 1'b1);
        step();
        check("t6_stale_ignored", {o_ir_valid, o_ir_out, o_dbg_state}, 0);
        lat_cfg = 1;
        exp_q = '{{16'h7777, 16'h0000}, {16'hF000, 16'h0001}};
        i_run = 1'b1;
        run_to_halt("t6_restart_timeout", 60, cyc);
        check("t6_drained", exp_q.size(), 0);

        // One instruction per row; run drops after the fetch starts.
        foreach (vecs[k]) begin
            do_reset(vecs[k].gd, vecs[k].lat, vecs[k].rd);
            pc_m = vecs[k].pc0; i_pc_in = vecs[k].pc0;
            mem[vecs[k].pc0[7:0]] = vecs[k].instr;
            exp_q.push_back({vecs[k].instr, vecs[k].pc0});
            i_run = 1'b1;
            step();
            i_run = 1'b0;
            cyc = 1;
            while (!o_pc_en && !o_halted && cyc < 40) begin step(); cyc++; end
            check($sformatf("vec%0d_cycles", k), cyc, vecs[k].e_cyc);
            check($sformatf("vec%0d_halted", k), o_halted, vecs[k].e_halt);
            if (!vecs[k].e_halt) begin
                check($sformatf("vec%0d_ctrl", k), {o_pc_en, o_pc_ctrl, o_offset_addr},
                      {1'b1, vecs[k].e_ctrl, vecs[k].e_off});
                step();
                check($sformatf("vec%0d_next_pc", k), pc_m, vecs[k].e_next);
                check($sformatf("vec%0d_idle", k), {o_imem_req, o_pc_en, o_dbg_state}, 0);
                step();
                check($sformatf("vec%0d_stay_idle", k), o_imem_req, 1'b0);
            end
        end

        // Random programs, timing and run level against the program-order model.
        rnd = 1'b1; spur = 1'b1;
        for (int r = 0; r < 6; r++) begin
            do_reset(0, 1, 0);
            for (int i = 0; i < 256; i++) begin
                case ($urandom_range(0, 11))
                    0:       mem[i] = {4'hF, 12'($urandom)};
                    1, 2:    mem[i] = {4'hA, 12'($urandom)};
                    default: mem[i] = {4'($urandom_range(0, 9)), 12'($urandom)};
                endcase
            end
            pcx = '0;
            last_hlt = 1'b0;
            for (int k = 0; k < 40; k++) begin
                w = mem[pcx[7:0]];
                exp_q.push_back({w, pcx});
                if (w[15:12] == 4'hF) begin last_hlt = 1'b1; break; end
                pcx = (w[15:12] == 4'hA) ? {8'h00, w[7:0]} : 16'(pcx + 1);
            end
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 3000) begin
                i_run = ($urandom_range(0, 4) != 0);
                step();
                cyc++;
            end
            if (exp_q.size() != 0) fail_now($sformatf("rand%0d_timeout", r));
            check($sformatf("rand%0d_halted", r), o_halted, last_hlt);
            check($sformatf("rand%0d_grants", r), n_gnt, n_acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
